macc_multi: RTL and testbench
=============================

// Module: macc_multi
// PURPOSE
//  Parametrised, pipelined multiply-accumulate unit; successor to the fixed 16-bit 3-factor MACC used by DFS cores.
//  - Each accepted op multiplies NOPS signed factors and adds or subtracts the product into one of NCHAN
//    independent accumulators.
//  - Optional saturation and a sticky per-channel overflow flag.
//  - Sits beside DFS_CORE as a shared arithmetic resource; one op per cycle, fully pipelined.
// PARAMETERS
//  WIDTH  16  bit width of each signed factor
//  NOPS   3   factors per product, 1..4
//  ACC_W  16  signed accumulator / result width
//  NCHAN  1   number of independent accumulators, >=1
//  SAT    0   0: wrap modulo 2^ACC_W; 1: clamp to signed ACC_W range
//  CW     max(1,$clog2(NCHAN))  channel index width (derived, localparam)
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           asynchronous reset, active-low (asserted when 0)
//  in_valid   in   1           op present this cycle
//  in_chan    in   CW          target accumulator
//  in_ops     in   NOPS*WIDTH  factors, factor k at [k*WIDTH +: WIDTH], signed
//  in_clear   in   1           start from 0 instead of current accumulator
//  in_sub     in   1           subtract product instead of add
//  out_valid  out  1           result of an op is valid
//  out_chan   out  CW          channel of the result
//  out_y      out  ACC_W       new accumulator value after the op, signed
//  out_ovf    out  1           sticky overflow flag of that channel, after the op
// BEHAVIOUR
//  Reset: asynchronous on rst==0. All pipeline valid bits, accumulators and sticky flags go to 0.
//    out_valid/out_chan/out_y/out_ovf read 0. In-flight ops are discarded, never emitted.
//  Pipeline: NOPS-1 multiply stages (stage k multiplies running product by factor k+1), then 1 accumulate stage.
//  Latency: an op with in_valid=1 at edge t gives out_valid=1 at edge t+NOPS. NOPS=1 gives latency 1.
//  Throughput: 1 op/cycle. in_valid=0 inserts a bubble that travels down the pipe.
//    A bubble leaves the accumulators untouched and gives out_valid=0.
//  Product: full precision, P = NOPS*WIDTH bits signed. No truncation before accumulation.
//  Accumulate (single cycle, read+write in same stage, so back-to-back ops on one channel need no forwarding):
//    base = in_clear ? 0 : acc[chan]
//    sum  = base + (in_sub ? -P : +P), computed at max(ACC_W,NOPS*WIDTH)+2 bits
//    ovf  = sum not representable in signed ACC_W
//    SAT=0: acc <= sum[ACC_W-1:0]
//    SAT=1: acc <= ovf ? (sum<0 ? -2^(ACC_W-1) : 2^(ACC_W-1)-1) : sum
//  Sticky flag: flag[chan] <= (in_clear ? 0 : flag[chan]) | ovf.
//    out_ovf reports the updated flag; out_y reports the updated acc.
//  Outputs are registered in the accumulate stage. out_* hold their last value while out_valid=0.
//  in_chan >= NCHAN: op is dropped at the accumulate stage. No update, out_valid stays 0.
//  Ops on different channels are fully independent. Interleaving does not disturb any channel.
//  Input fields are sampled only when in_valid=1. X on in_* is allowed while in_valid=0.
// TESTING
//  Directed scenarios, defaults unless noted.
//  1 Basic, NOPS=3, latency 3:
//    clear,add (2,3,4) at t0, then add (1,5,2) at t1, then sub (3,3,1) at t2.
//    Expect out_y=24 @t3, 34 @t4, 25 @t5; out_ovf=0 throughout.
//  2 Wrap, SAT=0:
//    clear,add (127,127,2), then add (127,127,2).
//    Expect out_y=32258, then -1020 with out_ovf=1. A following clear,add (1,1,1) gives 1 with out_ovf=0.
//  3 Saturation, SAT=1:
//    Same stimulus as scenario 2. Expect 32258, then 32767 with out_ovf=1.
//    Then clear,add (-32768,-32768,1) gives 32767, ovf=1.
//    Then clear,sub of that product gives -32768, ovf=1.
//  4 Channels, NCHAN=4:
//    Alternate ch0 clear (1,1,1) and ch3 clear (2,2,2), then add the same operands to each 3 times, back-to-back.
//    Expect ch0 results 1,2,3,4 and ch3 results 8,16,24,32, each in issue order with correct out_chan.
//    An op with in_chan=5 under NCHAN=5 is legal; with NCHAN=4 such an index cannot be driven.
//    With NCHAN=3, an op on chan 3 produces no out_valid.
//  5 Bubbles and reset:
//    Pattern valid,0,valid,0 gives out_valid 1,0,1,0 at latency 3.
//    Drive rst=0 mid-stream between edges. Expect all outputs 0 immediately, no later out_valid from pre-reset ops.
//    After release, add (1,1,1) without clear gives 1.
//  6 NOPS=1 / NOPS=4:
//    NOPS=1: add (7) then (-9) gives out_y 7 then -2, latency 1.
//    NOPS=4, ACC_W=40: clear (-3,5,7,2) gives -210 at latency 4.

Source files
------------

// File: rtl/macc_multi.sv
// Pipelined multiply-accumulate: NOPS signed factors are multiplied over NOPS-1 stages,
// then added to or subtracted from one of NCHAN accumulators with optional saturation.
module macc_multi #(
    parameter  int WIDTH = 16,
    parameter  int NOPS  = 3,
    parameter  int ACC_W = 16,
    parameter  int NCHAN = 1,
    parameter  int SAT   = 0,
    localparam int CW    = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [CW-1:0]           in_chan,
    input  logic [NOPS*WIDTH-1:0]   in_ops,
    input  logic                    in_clear,
    input  logic                    in_sub,
    output logic                    out_valid,
    output logic [CW-1:0]           out_chan,
    output logic signed [ACC_W-1:0] out_y,
    output logic                    out_ovf
);
    localparam int P  = NOPS * WIDTH;
    localparam int SW = ((ACC_W > P) ? ACC_W : P) + 2;
    localparam int L  = NOPS - 1;

    logic                   vld_q  [NOPS];
    logic                   vld_d  [NOPS];
    logic [CW-1:0]          chan_q [NOPS];
    logic [CW-1:0]          chan_d [NOPS];
    logic                   clr_q  [NOPS];
    logic                   clr_d  [NOPS];
    logic                   sub_q  [NOPS];
    logic                   sub_d  [NOPS];
    logic signed [P-1:0]    prod_q [NOPS];
    logic signed [P-1:0]    prod_d [NOPS];
    logic [P-1:0]           ops_q  [NOPS];
    logic [P-1:0]           ops_d  [NOPS];

    // Stage 0 registers the op with factor 0 as the running product; stage k folds in factor k.
    genvar gi;
    generate
        for (gi = 0; gi < NOPS; gi++) begin : g_stage
            if (gi == 0) begin : g_in
                assign vld_d[gi]  = in_valid;
                assign chan_d[gi] = in_chan;
                assign clr_d[gi]  = in_clear;
                assign sub_d[gi]  = in_sub;
                assign ops_d[gi]  = in_ops;
                assign prod_d[gi] = P'($signed(in_ops[WIDTH-1:0]));
            end else begin : g_mul
                assign vld_d[gi]  = vld_q[gi-1];
                assign chan_d[gi] = chan_q[gi-1];
                assign clr_d[gi]  = clr_q[gi-1];
                assign sub_d[gi]  = sub_q[gi-1];
                assign ops_d[gi]  = ops_q[gi-1];
                assign prod_d[gi] = prod_q[gi-1] * P'($signed(ops_q[gi-1][gi*WIDTH +: WIDTH]));
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NOPS; k++) begin
                vld_q[k]  <= 1'b0;
                chan_q[k] <= '0;
                clr_q[k]  <= 1'b0;
                sub_q[k]  <= 1'b0;
                prod_q[k] <= '0;
                ops_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NOPS; k++) begin
                vld_q[k] <= vld_d[k];
                if (vld_d[k]) begin
                    chan_q[k] <= chan_d[k];
                    clr_q[k]  <= clr_d[k];
                    sub_q[k]  <= sub_d[k];
                    prod_q[k] <= prod_d[k];
                    ops_q[k]  <= ops_d[k];
                end
            end
        end
    end

    logic signed [ACC_W-1:0] acc_q [NCHAN];
    logic [NCHAN-1:0]        flag_q;
    logic signed [ACC_W-1:0] acc_cur;
    logic                    flag_cur;
    logic signed [ACC_W-1:0] base;
    logic signed [SW-1:0]    base_ext;
    logic signed [SW-1:0]    prod_ext;
    logic signed [SW-1:0]    sum;
    logic signed [ACC_W-1:0] sum_trunc;
    logic                    ovf;
    logic                    chan_ok;
    logic                    acc_we;
    logic signed [ACC_W-1:0] acc_d;
    logic                    flag_d;
    logic signed [ACC_W-1:0] acc_max;
    logic signed [ACC_W-1:0] acc_min;

    assign acc_max = {1'b0, {(ACC_W-1){1'b1}}};
    assign acc_min = {1'b1, {(ACC_W-1){1'b0}}};

    always_comb begin
        acc_cur  = '0;
        flag_cur = 1'b0;
        for (int i = 0; i < NCHAN; i++) begin
            if (chan_q[L] == CW'(i)) begin
                acc_cur  = acc_q[i];
                flag_cur = flag_q[i];
            end
        end
    end

    // The sum is wide enough that neither add nor subtract can wrap before the range check.
    always_comb begin
        chan_ok   = (32'(chan_q[L]) < 32'(NCHAN));
        acc_we    = vld_q[L] && chan_ok;
        base      = clr_q[L] ? '0 : acc_cur;
        base_ext  = SW'(base);
        prod_ext  = SW'(prod_q[L]);
        sum       = sub_q[L] ? (base_ext - prod_ext) : (base_ext + prod_ext);
        sum_trunc = sum[ACC_W-1:0];
        ovf       = (SW'(sum_trunc) != sum);
        if ((SAT != 0) && ovf) begin
            acc_d = sum[SW-1] ? acc_min : acc_max;
        end else begin
            acc_d = sum_trunc;
        end
        flag_d = (clr_q[L] ? 1'b0 : flag_cur) | ovf;
    end

    logic                    out_valid_q;
    logic [CW-1:0]           out_chan_q;
    logic signed [ACC_W-1:0] out_y_q;
    logic                    out_ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCHAN; i++) begin
                acc_q[i] <= '0;
            end
            flag_q      <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_y_q     <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            out_valid_q <= acc_we;
            if (acc_we) begin
                for (int i = 0; i < NCHAN; i++) begin
                    if (chan_q[L] == CW'(i)) begin
                        acc_q[i]  <= acc_d;
                        flag_q[i] <= flag_d;
                    end
                end
                out_chan_q <= chan_q[L];
                out_y_q    <= acc_d;
                out_ovf_q  <= flag_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;
    assign out_y     = out_y_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_macc_multi.sv
// Scoreboard bench: three MACC configurations share one stimulus stream; a plain-arithmetic
// model predicts each result and a negedge monitor compares whatever the DUTs present.
module tb_macc_multi;
    localparam int NDUT = 3;
    localparam int NOPS_T [NDUT] = '{3, 3, 1};
    localparam int SAT_T  [NDUT] = '{0, 1, 0};

    typedef struct {
        int     cyc;
        int     ch;
        longint y;
        bit     ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  in_chan = '0;
    logic [47:0] in_ops = '0;
    logic        in_clear = 1'b0;
    logic        in_sub = 1'b0;

    logic               ov [NDUT];
    logic [1:0]         oc [NDUT];
    logic signed [15:0] oy [NDUT];
    logic               oo [NDUT];

    int     cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    exp_t   sbq [NDUT][$];
    exp_t   last [NDUT];
    longint acc_m [NDUT][3];
    bit     flg_m [NDUT][3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    macc_multi #(.WIDTH(16), .NOPS(3), .ACC_W(16), .NCHAN(3), .SAT(0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_chan(in_chan), .in_ops(in_ops),
        .in_clear(in_clear), .in_sub(in_sub),
        .out_valid(ov[0]), .out_chan(oc[0]), .out_y(oy[0]), .out_ovf(oo[0]));

    macc_multi #(.WIDTH(16), .NOPS(3), .ACC_W(16), .NCHAN(3), .SAT(1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_chan(in_chan), .in_ops(in_ops),
        .in_clear(in_clear), .in_sub(in_sub),
        .out_valid(ov[1]), .out_chan(oc[1]), .out_y(oy[1]), .out_ovf(oo[1]));

    macc_multi #(.WIDTH(16), .NOPS(1), .ACC_W(16), .NCHAN(3), .SAT(0)) dut_one (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_chan(in_chan), .in_ops(in_ops[15:0]),
        .in_clear(in_clear), .in_sub(in_sub),
        .out_valid(ov[2]), .out_chan(oc[2]), .out_y(oy[2]), .out_ovf(oo[2]));

    function automatic longint wrap16(input longint v);
        longint w;
        w = v & 64'hFFFF;
        if (w > 32767) w = w - 65536;
        return w;
    endfunction

    task automatic model_op(input int ch, input bit clr, input bit sb,
                            input longint f0, input longint f1, input longint f2);
        longint p, base, sum, y;
        bit     ovf;
        if (ch >= 3) return;
        for (int d = 0; d < NDUT; d++) begin
            p    = (NOPS_T[d] == 1) ? f0 : f0 * f1 * f2;
            base = clr ? 64'sd0 : acc_m[d][ch];
            sum  = sb ? base - p : base + p;
            ovf  = (sum > 32767) || (sum < -32768);
            if (ovf && SAT_T[d] != 0) y = (sum < 0) ? -32768 : 32767;
            else y = wrap16(sum);
            acc_m[d][ch] = y;
            flg_m[d][ch] = (clr ? 1'b0 : flg_m[d][ch]) | ovf;
            sbq[d].push_back('{cyc: cyc + 1 + NOPS_T[d], ch: ch, y: y, ovf: flg_m[d][ch]});
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < NDUT; d++) begin
            sbq[d].delete();
            last[d] = '{cyc: 0, ch: 0, y: 0, ovf: 1'b0};
            for (int c = 0; c < 3; c++) begin
                acc_m[d][c] = 0;
                flg_m[d][c] = 1'b0;
            end
        end
    endtask

    // Fields are randomised while in_valid=0 since the DUT must ignore them.
    task automatic issue(input bit v, input int ch, input bit clr, input bit sb,
                         input longint f0, input longint f1, input longint f2);
        @(posedge clk);
        #1;
        in_valid = v;
        if (v) begin
            in_chan  = 2'(ch);
            in_clear = clr;
            in_sub   = sb;
            in_ops   = {16'(f2), 16'(f1), 16'(f0)};
            model_op(ch, clr, sb, f0, f1, f2);
        end else begin
            in_chan  = 2'($urandom);
            in_clear = 1'($urandom);
            in_sub   = 1'($urandom);
            in_ops   = {$urandom, $urandom};
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        in_valid = 1'b0;
        clear_model();
        #1;
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (ov[d] !== 1'b0 || oc[d] !== 2'd0 || oy[d] !== 16'sd0 || oo[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: got v=%0b ch=%0d y=%0d ovf=%0b, want all 0",
                         d, ov[d], oc[d], oy[d], oo[d]);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic check_dut(input int d);
        bit   expv;
        exp_t e;
        while (sbq[d].size() > 0 && sbq[d][0].cyc < cyc) void'(sbq[d].pop_front());
        expv = 1'b0;
        if (sbq[d].size() > 0) expv = (sbq[d][0].cyc == cyc);
        n_checks++;
        if (ov[d] !== expv) begin
            n_fail++;
            $display("FAIL out_valid dut%0d cyc %0d: got %0b, want %0b", d, cyc, ov[d], expv);
        end
        if (expv) begin
            e = sbq[d].pop_front();
            n_checks++;
            if (32'(oc[d]) != e.ch || longint'(oy[d]) != e.y || oo[d] !== e.ovf) begin
                n_fail++;
                $display("FAIL result dut%0d cyc %0d: got ch=%0d y=%0d ovf=%0b, want ch=%0d y=%0d ovf=%0b",
                         d, cyc, oc[d], oy[d], oo[d], e.ch, e.y, e.ovf);
            end else begin
                $display("dut%0d cyc %0d ch=%0d y=%0d ovf=%0b ok", d, cyc, oc[d], oy[d], oo[d]);
            end
            last[d] = e;
        end else if (ov[d] !== 1'b1) begin
            n_checks++;
            if (32'(oc[d]) != last[d].ch || longint'(oy[d]) != last[d].y || oo[d] !== last[d].ovf) begin
                n_fail++;
                $display("FAIL hold dut%0d cyc %0d: got ch=%0d y=%0d ovf=%0b, want ch=%0d y=%0d ovf=%0b",
                         d, cyc, oc[d], oy[d], oo[d], last[d].ch, last[d].y, last[d].ovf);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) check_dut(d);
    end

    function automatic longint rnd_factor();
        if ($urandom_range(0, 1) == 0) return longint'($urandom_range(0, 40)) - 20;
        return longint'(shortint'($urandom));
    endfunction

    initial begin
        clear_model();
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Basic accumulate, then add and subtract.
        issue(1, 0, 1, 0, 2, 3, 4);
        issue(1, 0, 0, 0, 1, 5, 2);
        issue(1, 0, 0, 1, 3, 3, 1);
        // Wrap / saturation and sticky flag clearing.
        issue(1, 0, 1, 0, 127, 127, 2);
        issue(1, 0, 0, 0, 127, 127, 2);
        issue(1, 0, 1, 0, 1, 1, 1);
        issue(1, 0, 1, 0, -32768, -32768, 1);
        issue(1, 0, 1, 1, -32768, -32768, 1);
        // Interleaved channels, then an out-of-range channel.
        issue(1, 0, 1, 0, 1, 1, 1);
        issue(1, 2, 1, 0, 2, 2, 2);
        for (int r = 0; r < 3; r++) begin
            issue(1, 0, 0, 0, 1, 1, 1);
            issue(1, 2, 0, 0, 2, 2, 2);
        end
        issue(1, 3, 1, 0, 9, 9, 9);
        issue(1, 1, 1, 0, 7, 1, 1);
        issue(1, 1, 0, 0, -9, 1, 1);
        // Bubbles.
        issue(1, 1, 1, 0, 1, 2, 3);
        issue(0, 0, 0, 0, 0, 0, 0);
        issue(1, 1, 0, 0, 1, 1, 1);
        issue(0, 0, 0, 0, 0, 0, 0);
        // Reset with ops in flight.
        issue(1, 0, 0, 0, 5, 5, 5);
        issue(1, 1, 0, 0, 5, 5, 5);
        do_reset();
        issue(1, 0, 0, 0, 1, 1, 1);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            issue($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                  $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
                  rnd_factor(), rnd_factor(), rnd_factor());
        end
        for (int i = 0; i < 8; i++) issue(0, 0, 0, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (sbq[d].size() != 0) begin
                n_fail++;
                $display("FAIL drain dut%0d: %0d results never appeared, want 0", d, sbq[d].size());
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
